// File: rtl/reg_write_arbiter_if.sv
// reg_write_arbiter_if: groups the requester handshake and register-file write bus.
//
// Signals
//   Hold                      : suppresses new grants while high
//   Req_0/1/2                 : requester i wants the register-file write port
//   Dst_0/1/2 [1:0]           : destination register R0-R3 for requester i
//   Data_0/1/2 [WIDTH-1:0]    : write data for requester i
//   Ack_0/1/2                 : combinational grant/capture strobe for requester i
//   Select [1:0]              : registered register select for the load demux
//   Load_DST                  : registered one-cycle write strobe
//   Write_Data [WIDTH-1:0]    : registered write data
//   Reg_Busy [3:0]            : one-hot of Select while Load_DST is high
//   Write_Count [7:0]         : completed writes, wrapping
//
// Modports
//   master : requester/register-file side (drives requests, observes results)
//   slave  : the arbiter
interface reg_write_arbiter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             Hold;
  logic             Req_0;
  logic             Req_1;
  logic             Req_2;
  logic [1:0]       Dst_0;
  logic [1:0]       Dst_1;
  logic [1:0]       Dst_2;
  logic [WIDTH-1:0] Data_0;
  logic [WIDTH-1:0] Data_1;
  logic [WIDTH-1:0] Data_2;
  logic             Ack_0;
  logic             Ack_1;
  logic             Ack_2;
  logic [1:0]       Select;
  logic             Load_DST;
  logic [WIDTH-1:0] Write_Data;
  logic [3:0]       Reg_Busy;
  logic [7:0]       Write_Count;

  modport master (
    output Hold,
    output Req_0, Req_1, Req_2,
    output Dst_0, Dst_1, Dst_2,
    output Data_0, Data_1, Data_2,
    input  Ack_0, Ack_1, Ack_2,
    input  Select, Load_DST, Write_Data, Reg_Busy, Write_Count
  );

  modport slave (
    input  Hold,
    input  Req_0, Req_1, Req_2,
    input  Dst_0, Dst_1, Dst_2,
    input  Data_0, Data_1, Data_2,
    output Ack_0, Ack_1, Ack_2,
    output Select, Load_DST, Write_Data, Reg_Busy, Write_Count
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: three-requester round-robin arbiter for a single register-file
// write port. A grant (Ack_i) is combinational; the granted destination and data are
// registered on the grant edge and presented with Load_DST for exactly one cycle, so a
// write can be issued every cycle.
//
// Ports
//   Clock   : single clock, rising edge
//   Reset_n : asynchronous active-low reset
//   bus     : reg_write_arbiter_if.slave (requests in, acks and write bus out)
//
// WIDTH must match the WIDTH of the connected interface instance.
module reg_write_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input logic               Clock,
  input logic               Reset_n,
  reg_write_arbiter_if.slave bus
);

  logic [2:0]       req;
  logic [2:0]       gnt;
  logic             gnt_any;
  logic [1:0]       gnt_idx;
  logic [1:0]       sel_d;
  logic [WIDTH-1:0] data_d;

  logic [1:0]       last_q;
  logic             load_q;
  logic [1:0]       sel_q;
  logic [WIDTH-1:0] data_q;
  logic [7:0]       count_q;

  assign req = {bus.Req_2, bus.Req_1, bus.Req_0};

  // Round-robin: the requester after Last has highest priority, Last itself lowest.
  // Grants are masked in reset so every Ack reads 0 as soon as Reset_n falls.
  always_comb begin
    gnt = 3'b000;
    if (Reset_n && !bus.Hold) begin
      unique case (last_q)
        2'd0: begin
          if      (req[1]) gnt = 3'b010;
          else if (req[2]) gnt = 3'b100;
          else if (req[0]) gnt = 3'b001;
        end
        2'd1: begin
          if      (req[2]) gnt = 3'b100;
          else if (req[0]) gnt = 3'b001;
          else if (req[1]) gnt = 3'b010;
        end
        default: begin
          if      (req[0]) gnt = 3'b001;
          else if (req[1]) gnt = 3'b010;
          else if (req[2]) gnt = 3'b100;
        end
      endcase
    end
  end

  assign gnt_any = |gnt;

  always_comb begin
    gnt_idx = 2'd0;
    if (gnt[1]) gnt_idx = 2'd1;
    if (gnt[2]) gnt_idx = 2'd2;
  end

  always_comb begin
    sel_d  = bus.Dst_0;
    data_d = bus.Data_0;
    unique case (gnt_idx)
      2'd1: begin
        sel_d  = bus.Dst_1;
        data_d = bus.Data_1;
      end
      2'd2: begin
        sel_d  = bus.Dst_2;
        data_d = bus.Data_2;
      end
      default: begin
        sel_d  = bus.Dst_0;
        data_d = bus.Data_0;
      end
    endcase
  end

  // Select/Write_Data/Last only move on a grant; Load_DST follows the grant by one
  // cycle. Reset clears load_q, which discards any staged write before it counts.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      last_q  <= 2'd2;
      load_q  <= 1'b0;
      sel_q   <= 2'd0;
      data_q  <= '0;
      count_q <= 8'd0;
    end else begin
      load_q <= gnt_any;
      if (gnt_any) begin
        last_q <= gnt_idx;
        sel_q  <= sel_d;
        data_q <= data_d;
      end
      if (load_q) begin
        count_q <= count_q + 8'd1;
      end
    end
  end

  assign bus.Ack_0       = gnt[0];
  assign bus.Ack_1       = gnt[1];
  assign bus.Ack_2       = gnt[2];
  assign bus.Select      = sel_q;
  assign bus.Load_DST    = load_q;
  assign bus.Write_Data  = data_q;
  assign bus.Reg_Busy    = load_q ? (4'b0001 << sel_q) : 4'b0000;
  assign bus.Write_Count = count_q;

  a_ack_onehot0 : assert property (@(posedge Clock) disable iff (!Reset_n) $onehot0(gnt));
  a_last_legal  : assert property (@(posedge Clock) disable iff (!Reset_n) last_q != 2'd3);

endmodule
